tm_association_lookup: RTL
==========================

TM_ASSOCIATION_LOOKUP -- requirements
Module: tm_association_lookup

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of poll requesters.
REQ-002 SHALL have parameter QID_NBITS, default `FIRST_LVL_QUEUE_ID_NBITS: poll queue id / RAM address width.
REQ-003 SHALL have parameters CONN_NBITS, GRP_NBITS, PQ_NBITS, PORT_NBITS, defaulting to `SECOND_LVL_QUEUE_ID_NBITS, `THIRD_LVL_QUEUE_ID_NBITS, `FOURTH_LVL_QUEUE_ID_NBITS and `PORT_ID_NBITS; these are the association field widths.
REQ-004 SHALL have parameter OUTSTANDING, default 4 (power of 2, >=2): maximum number of RAM reads in flight.
REQ-005 SHALL define ports as follows; ASSOC_NBITS is CONN_NBITS+GRP_NBITS+PQ_NBITS+PORT_NBITS:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- poll_req  in  NUM_REQ  per-requester lookup request.
- poll_qid  in  NUM_REQ*QID_NBITS  per-requester queue id; requester i occupies slice i.
- poll_ready  out  NUM_REQ  one-hot grant; the request is accepted in the cycle where both req and ready are high.
- queue_association_rd  out  1  RAM read strobe.
- queue_association_raddr  out  QID_NBITS  RAM read address.
- queue_association_ack  in  1  RAM read data valid, returned in issue order.
- queue_association_rdata  in  ASSOC_NBITS+1  MSB is even parity; below it {port, port_queue, conn_group, conn}, with conn in the LSBs.
- poll_association_ack  out  NUM_REQ  one-hot response strobe to the owning requester.
- association_conn_id / association_conn_group_id / association_port_queue_id / association_port_id  out  field widths  shared response fields.
- association_parity_err  out  1  qualifies the current response.
- unexpected_ack_err  out  1  sticky error flag.

Function
REQ-006 Arbitration SHALL be round-robin over requesters with poll_req high.
REQ-007 The round-robin pointer SHALL move to (granted index + 1) mod NUM_REQ after each accepted request.
REQ-008 poll_ready SHALL be combinational: it is all-zero when the in-flight count equals OUTSTANDING, otherwise one-hot on the winner.
REQ-009 An accept in cycle N SHALL produce queue_association_rd=1 and raddr=the winner's qid in cycle N+1, each for one cycle.
REQ-010 When no accept occurs, rd SHALL be 0 and raddr SHALL hold its value.
REQ-011 Each accept SHALL push the granted index into an in-order tag FIFO of depth OUTSTANDING.
REQ-012 In-flight count SHALL increment on accept and decrement on a consumed ack; if both occur in the same cycle it is unchanged.
REQ-013 An ack in cycle M with the tag FIFO non-empty SHALL pop the FIFO.
REQ-014 That ack SHALL, in cycle M+1, assert poll_association_ack[tag] for one cycle and register the unpacked fields.
REQ-015 The response fields SHALL hold their values until the next consumed ack.
REQ-016 An ack with the tag FIFO empty SHALL be dropped: no poll_association_ack, fields unchanged, and unexpected_ack_err set to 1 until reset.
REQ-017 FIFO pointers SHALL wrap modulo OUTSTANDING; full and empty SHALL be distinguished by the in-flight count, never by pointer equality alone.
REQ-018 Back-to-back accepts, one per cycle, SHALL be sustained while not full.
REQ-019 Acks SHALL be accepted every cycle.

Reset
REQ-020 While rst is high, rd, poll_association_ack, association_parity_err, unexpected_ack_err, the in-flight count, the FIFO pointers and the RR pointer SHALL be 0.
REQ-021 While rst is high, raddr and the four response fields SHALL be 0.
REQ-022 Reset mid-operation SHALL discard all in-flight tags.
REQ-023 Acks arriving after reset for reads issued before reset SHALL be treated as unexpected per REQ-016.

Configuration
REQ-024 With macro TM_ASSOC_PARITY_CHECK_EN defined, association_parity_err SHALL be registered alongside each response and equal 1 when the XOR of all ASSOC_NBITS+1 rdata bits is 1.
REQ-025 With TM_ASSOC_PARITY_CHECK_EN defined, the response SHALL still be delivered when parity fails.
REQ-026 Without TM_ASSOC_PARITY_CHECK_EN, the rdata MSB SHALL be ignored and association_parity_err SHALL be constant 0.

Verification
REQ-027 Single read: req[2]=1 with qid=0x15 -> ready[2] in the same cycle, rd=1 with raddr=0x15 next cycle; ack with rdata fields conn=3, port=1 -> poll_association_ack=4'b0100 one cycle later with conn=3 and port=1.
REQ-028 Round-robin: all four req held high -> grants 0,1,2,3,0 on consecutive cycles while ack keeps pace.
REQ-029 Full: 4 accepts with no ack -> poll_ready=0; one ack -> ready reasserts the cycle after, and the response goes to the first-granted requester.
REQ-030 Unexpected ack: ack with nothing in flight -> no poll_association_ack; unexpected_ack_err=1 and held until rst.
REQ-031 Parity (macro defined): rdata with an odd number of 1s -> association_parity_err=1 alongside the ack.
REQ-032 Parity (macro undefined): the same rdata -> association_parity_err=0.
REQ-033 Reset mid-flight: 2 reads in flight, pulse rst, then 2 acks -> no responses; unexpected_ack_err=1.

Source files
------------

// File: rtl/tm_association_lookup.sv
// ============================================================================
// Module  : tm_association_lookup
// Brief   : Round-robin poll arbiter for queue-association RAM lookups, with an
//           in-order tag FIFO that routes read data back to the owning requester.
//           Optional parity checking is enabled by TM_ASSOC_PARITY_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef THIRD_LVL_QUEUE_ID_NBITS
`define THIRD_LVL_QUEUE_ID_NBITS 6
`endif
`ifndef FOURTH_LVL_QUEUE_ID_NBITS
`define FOURTH_LVL_QUEUE_ID_NBITS 4
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 3
`endif

module tm_association_lookup #(
    parameter int NUM_REQ     = 4,
    parameter int QID_NBITS   = `FIRST_LVL_QUEUE_ID_NBITS,
    parameter int CONN_NBITS  = `SECOND_LVL_QUEUE_ID_NBITS,
    parameter int GRP_NBITS   = `THIRD_LVL_QUEUE_ID_NBITS,
    parameter int PQ_NBITS    = `FOURTH_LVL_QUEUE_ID_NBITS,
    parameter int PORT_NBITS  = `PORT_ID_NBITS,
    parameter int OUTSTANDING = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_REQ-1:0]                                poll_req,
    input  logic [NUM_REQ*QID_NBITS-1:0]                      poll_qid,
    output logic [NUM_REQ-1:0]                                poll_ready,
    output logic                                              queue_association_rd,
    output logic [QID_NBITS-1:0]                              queue_association_raddr,
    input  logic                                              queue_association_ack,
    input  logic [CONN_NBITS+GRP_NBITS+PQ_NBITS+PORT_NBITS:0] queue_association_rdata,
    output logic [NUM_REQ-1:0]                                poll_association_ack,
    output logic [CONN_NBITS-1:0]                             association_conn_id,
    output logic [GRP_NBITS-1:0]                              association_conn_group_id,
    output logic [PQ_NBITS-1:0]                               association_port_queue_id,
    output logic [PORT_NBITS-1:0]                             association_port_id,
    output logic                                              association_parity_err,
    output logic                                              unexpected_ack_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int F_GRP  = CONN_NBITS;
    localparam int F_PQ   = F_GRP + GRP_NBITS;
    localparam int F_PORT = F_PQ + PQ_NBITS;
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(OUTSTANDING);

    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_win_idx;
    logic [IDX_W-1:0]      w_rr_next;
    logic                  w_any_req;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_consume;
    logic                  w_unexpected;
    logic [NUM_REQ-1:0]    w_grant;
    logic [QID_NBITS-1:0]  w_win_qid;
    logic [CNT_W-1:0]      r_inflight;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [IDX_W-1:0]      r_tag_mem [OUTSTANDING];
    logic [IDX_W-1:0]      w_head_tag;

    logic                  r_rd;
    logic [QID_NBITS-1:0]  r_raddr;
    logic [NUM_REQ-1:0]    r_resp;
    logic [CONN_NBITS-1:0] r_conn;
    logic [GRP_NBITS-1:0]  r_grp;
    logic [PQ_NBITS-1:0]   r_pq;
    logic [PORT_NBITS-1:0] r_port;
    logic                  r_unexp;

    // Scan from the highest offset down so the nearest requester after r_rr_ptr wins.
    always_comb begin
        logic [IDX_W-1:0] v_idx;
        w_any_req = 1'b0;
        w_win_idx = '0;
        v_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (poll_req[v_idx]) begin
                w_any_req = 1'b1;
                w_win_idx = v_idx;
            end
        end
    end

    assign w_full       = (r_inflight == c_full_cnt);
    assign w_grant      = (w_any_req && !w_full) ? (NUM_REQ'(1) << w_win_idx) : '0;
    assign w_accept     = |(poll_req & w_grant);
    assign w_consume    = queue_association_ack && (r_inflight != '0);
    assign w_unexpected = queue_association_ack && (r_inflight == '0);
    assign w_head_tag   = r_tag_mem[r_rd_ptr];
    assign w_win_qid    = poll_qid[int'(w_win_idx)*QID_NBITS +: QID_NBITS];
    assign w_rr_next    = (int'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_wr_ptr] <= w_win_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd       <= 1'b0;
            r_raddr    <= '0;
            r_resp     <= '0;
            r_conn     <= '0;
            r_grp      <= '0;
            r_pq       <= '0;
            r_port     <= '0;
            r_unexp    <= 1'b0;
        end else begin
            r_rd <= w_accept;
            if (w_accept) begin
                r_raddr  <= w_win_qid;
                r_rr_ptr <= w_rr_next;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_consume) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_resp   <= NUM_REQ'(1) << w_head_tag;
                r_conn   <= queue_association_rdata[CONN_NBITS-1:0];
                r_grp    <= queue_association_rdata[F_GRP +: GRP_NBITS];
                r_pq     <= queue_association_rdata[F_PQ +: PQ_NBITS];
                r_port   <= queue_association_rdata[F_PORT +: PORT_NBITS];
            end else begin
                r_resp   <= '0;
            end
            case ({w_accept, w_consume})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (w_unexpected) begin
                r_unexp <= 1'b1;
            end
        end
    end

`ifdef TM_ASSOC_PARITY_CHECK_EN
    logic r_par_err;

    // Parity is even over the whole word, so any odd XOR flags the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_consume) begin
            r_par_err <= ^queue_association_rdata;
        end
    end

    assign association_parity_err = r_par_err;
`else
    logic w_unused_parity_bit;

    assign w_unused_parity_bit    = queue_association_rdata[F_PORT + PORT_NBITS];
    assign association_parity_err = 1'b0;
`endif

    assign poll_ready                = w_grant;
    assign queue_association_rd      = r_rd;
    assign queue_association_raddr   = r_raddr;
    assign poll_association_ack      = r_resp;
    assign association_conn_id       = r_conn;
    assign association_conn_group_id = r_grp;
    assign association_port_queue_id = r_pq;
    assign association_port_id       = r_port;
    assign unexpected_ack_err        = r_unexp;

endmodule

`default_nettype wire
